fetch_unit: RTL and testbench

- Instruction-fetch sequencer directly downstream of pc: consumes pc's out, drives pc's in/store, reads instruction memory, presents one instruction at a time to decode over a valid/ready handshake.
- Handles branch redirect from execute and halts on a HALT opcode.
- pc and imem are separate instances; this block holds only the FSM and the instruction/PC output registers.

---
 rtl/fetch_unit.sv | 132 +++++++++++++
 tb/tb_fetch_unit.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: drives the external pc register and a registered-read
// instruction memory, and hands one instruction at a time to decode over valid/ready.
module fetch_unit #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned PC_INC  = 1,
  parameter logic [3:0]  HALT_OP = 4'hF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_val,
  output logic [WIDTH-1:0] pc_next,
  output logic             pc_store,
  output logic [WIDTH-1:0] imem_addr,
  output logic             imem_rd,
  input  logic [WIDTH-1:0] imem_data,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc,
  output logic             instr_valid,
  input  logic             instr_ready,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             halt
);

  localparam int unsigned OP_W = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT   = 3'd2,
    VALID  = 3'd3,
    HALTED = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] ipc_q, ipc_d;
  logic             valid_q, valid_d;
  logic             halt_q, halt_d;
  logic [OP_W-1:0]  opcode;

  assign opcode = instr_q[WIDTH-1 -: OP_W];

  // Next state, next register values and the pc/imem strobes that act in the current cycle
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    ipc_d     = ipc_q;
    valid_d   = valid_q;
    halt_d    = halt_q;
    pc_next   = pc_val;
    pc_store  = 1'b0;
    imem_rd   = 1'b0;
    imem_addr = pc_val;

    unique case (state_q)
      IDLE: begin
        state_d = ISSUE;
      end
      ISSUE: begin
        imem_rd = 1'b1;
        if (redirect) begin
          pc_store = 1'b1;
          pc_next  = redirect_pc;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          pc_store = 1'b1;
          pc_next  = redirect_pc;
          state_d  = ISSUE;
        end else begin
          instr_d  = imem_data;
          ipc_d    = pc_val;
          valid_d  = 1'b1;
          pc_store = 1'b1;
          pc_next  = pc_val + WIDTH'(PC_INC);
          state_d  = VALID;
        end
      end
      VALID: begin
        // A redirect wins over the handshake: the held instruction is dropped unseen
        if (redirect) begin
          pc_store = 1'b1;
          pc_next  = redirect_pc;
          valid_d  = 1'b0;
          state_d  = ISSUE;
        end else if (instr_ready) begin
          valid_d = 1'b0;
          if (opcode == HALT_OP) begin
            halt_d  = 1'b1;
            state_d = HALTED;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      HALTED: begin
        valid_d = 1'b0;
        halt_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      instr_q <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
      halt_q  <= halt_d;
    end
  end

  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = valid_q;
  assign halt        = halt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: models the pc register and imem, scoreboards accepted instructions.
module tb_fetch_unit;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [15:0] pc_reg;
  logic [15:0] pc_next;
  logic        pc_store;
  logic [15:0] imem_addr;
  logic        imem_rd;
  logic [15:0] imem_data;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;

  logic        preset_en;
  logic [15:0] preset_val;
  logic        halt_en;
  logic [15:0] halt_addr;

  exp_t sb_q[$];
  exp_t sb_e;
  int   vectors;
  int   miscompares;

  fetch_unit #(.WIDTH(16), .PC_INC(1), .HALT_OP(4'hF)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_val      (pc_reg),
    .pc_next     (pc_next),
    .pc_store    (pc_store),
    .imem_addr   (imem_addr),
    .imem_rd     (imem_rd),
    .imem_data   (imem_data),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (halt_en && a == halt_addr) return 16'hF000;
    return a + 16'h1000;
  endfunction

  // pc register model (presettable by the bench) and registered-read imem model
  always @(posedge clk) begin
    if (preset_en) pc_reg <= preset_val;
    else if (pc_store) pc_reg <= pc_next;
  end

  always @(posedge clk) begin
    if (imem_rd) imem_data <= mem_word(imem_addr);
  end

  // Scoreboard: every accepted instruction must match the oldest expectation
  always @(negedge clk) begin
    if (rst === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1 && redirect === 1'b0) begin
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected: accepted instr=%h pc=%h, required none", instr, instr_pc);
      end else begin
        sb_e = sb_q.pop_front();
        if (instr !== sb_e.instr || instr_pc !== sb_e.pc) begin
          miscompares++;
          $display("FAIL sb_accept: got instr=%h pc=%h, required instr=%h pc=%h",
                   instr, instr_pc, sb_e.instr, sb_e.pc);
        end
      end
    end
  end

  task automatic reset_dut(input logic [15:0] start_pc);
    rst         = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    halt_en     = 1'b0;
    halt_addr   = 16'h0000;
    preset_en   = 1'b1;
    preset_val  = start_pc;
    sb_q.delete();
    @(posedge clk); #1;
    preset_en = 1'b0;
    rst       = 1'b1;
  endtask

  task automatic test_reset;
    rst         = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    halt_en     = 1'b0;
    preset_en   = 1'b1;
    preset_val  = 16'h0123;
    @(posedge clk); #1;
    preset_en = 1'b0;
    vectors++;
    if ({instr, instr_pc, instr_valid, halt} !== 34'h0) begin
      miscompares++;
      $display("FAIL reset_regs: got instr=%h pc=%h v=%b h=%b, required all 0", instr, instr_pc, instr_valid, halt);
    end
    vectors++;
    if (pc_store !== 1'b0 || imem_rd !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_strobes: got store=%b rd=%b, required 0 0", pc_store, imem_rd);
    end
    vectors++;
    if (pc_next !== 16'h0123 || imem_addr !== 16'h0123) begin
      miscompares++;
      $display("FAIL reset_addr: got next=%h addr=%h, required 0123 0123", pc_next, imem_addr);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (imem_rd !== 1'b1 || imem_addr !== 16'h0123 || pc_store !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_first_issue: got rd=%b addr=%h store=%b, required 1 0123 0", imem_rd, imem_addr, pc_store);
    end
  endtask

  task automatic test_sequential;
    logic [10:0] vmask, smask, rmask;
    vmask = '0; smask = '0; rmask = '0;
    reset_dut(16'h0000);
    instr_ready = 1'b1;
    for (int k = 0; k < 3; k++) sb_q.push_back('{instr: 16'h1000 + 16'(k), pc: 16'(k)});
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      vmask[c] = instr_valid;
      smask[c] = pc_store;
      rmask[c] = imem_rd;
    end
    vectors++;
    if (vmask !== 11'h248) begin
      miscompares++;
      $display("FAIL seq_valid_mask: got %h, required 248", vmask);
    end
    vectors++;
    if (smask !== 11'h124) begin
      miscompares++;
      $display("FAIL seq_store_mask: got %h, required 124", smask);
    end
    vectors++;
    if (rmask !== 11'h492) begin
      miscompares++;
      $display("FAIL seq_rd_mask: got %h, required 492", rmask);
    end
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL seq_drain: got %0d pending, required 0", sb_q.size());
    end
  endtask

  task automatic test_stall;
    int bad;
    int n;
    bad = 0;
    reset_dut(16'h0000);
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (instr_valid !== 1'b1 || instr !== 16'h1000 || instr_pc !== 16'h0000) begin
      miscompares++;
      $display("FAIL stall_first: got v=%b instr=%h pc=%h, required 1 1000 0000", instr_valid, instr, instr_pc);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (instr !== 16'h1000 || instr_pc !== 16'h0000 || pc_reg !== 16'h0001 ||
          imem_rd !== 1'b0 || instr_valid !== 1'b1 || pc_store !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL stall_hold: got %0d unstable cycles, required 0", bad);
    end
    sb_q.push_back('{instr: 16'h1000, pc: 16'h0000});
    sb_q.push_back('{instr: 16'h1001, pc: 16'h0001});
    instr_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (imem_rd !== 1'b1 || imem_addr !== 16'h0001) begin
      miscompares++;
      $display("FAIL stall_resume: got rd=%b addr=%h, required 1 0001", imem_rd, imem_addr);
    end
    n = 0;
    while (sb_q.size() != 0 && n < 10) begin
      @(posedge clk); #1; n++;
    end
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL stall_drain: got %0d pending, required 0", sb_q.size());
    end
  endtask

  task automatic test_redirect_wait;
    int n;
    reset_dut(16'h0000);
    instr_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    redirect    = 1'b1;
    redirect_pc = 16'h0040;
    #1;
    vectors++;
    if (pc_store !== 1'b1 || pc_next !== 16'h0040) begin
      miscompares++;
      $display("FAIL rdw_strobe: got store=%b next=%h, required 1 0040", pc_store, pc_next);
    end
    @(posedge clk); #1;
    redirect = 1'b0;
    vectors++;
    if (instr_valid !== 1'b0 || pc_reg !== 16'h0040) begin
      miscompares++;
      $display("FAIL rdw_discard: got v=%b pc=%h, required 0 0040", instr_valid, pc_reg);
    end
    sb_q.push_back('{instr: 16'h1040, pc: 16'h0040});
    n = 0;
    while (sb_q.size() != 0 && n < 10) begin
      @(posedge clk); #1; n++;
    end
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL rdw_drain: got %0d pending, required 0", sb_q.size());
    end
  endtask

  task automatic test_redirect_valid;
    int n;
    reset_dut(16'h0000);
    repeat (3) @(posedge clk);
    #1;
    instr_ready = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 16'h0080;
    #1;
    vectors++;
    if (instr_valid !== 1'b1 || pc_store !== 1'b1 || pc_next !== 16'h0080) begin
      miscompares++;
      $display("FAIL rdv_strobe: got v=%b store=%b next=%h, required 1 1 0080", instr_valid, pc_store, pc_next);
    end
    @(posedge clk); #1;
    redirect = 1'b0;
    vectors++;
    if (instr_valid !== 1'b0 || pc_reg !== 16'h0080 || imem_rd !== 1'b1) begin
      miscompares++;
      $display("FAIL rdv_drop: got v=%b pc=%h rd=%b, required 0 0080 1", instr_valid, pc_reg, imem_rd);
    end
    sb_q.push_back('{instr: 16'h1080, pc: 16'h0080});
    n = 0;
    while (sb_q.size() != 0 && n < 10) begin
      @(posedge clk); #1; n++;
    end
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL rdv_drain: got %0d pending, required 0", sb_q.size());
    end
  endtask

  task automatic test_wrap;
    int n;
    reset_dut(16'hFFFF);
    instr_ready = 1'b1;
    sb_q.push_back('{instr: 16'h0FFF, pc: 16'hFFFF});
    sb_q.push_back('{instr: 16'h1000, pc: 16'h0000});
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL wrap_drain: got %0d pending, required 0", sb_q.size());
    end
  endtask

  task automatic test_halt;
    int n;
    int bad;
    bad = 0;
    reset_dut(16'h0000);
    halt_en     = 1'b1;
    halt_addr   = 16'h0003;
    instr_ready = 1'b1;
    for (int k = 0; k < 3; k++) sb_q.push_back('{instr: 16'h1000 + 16'(k), pc: 16'(k)});
    sb_q.push_back('{instr: 16'hF000, pc: 16'h0003});
    n = 0;
    while (halt !== 1'b1 && n < 30) begin
      @(posedge clk); #1; n++;
    end
    vectors++;
    if (halt !== 1'b1) begin
      miscompares++;
      $display("FAIL halt_timeout: got halt=%b, required 1", halt);
    end
    vectors++;
    if (sb_q.size() != 0 || instr_valid !== 1'b0 || pc_reg !== 16'h0004) begin
      miscompares++;
      $display("FAIL halt_state: got pending=%0d v=%b pc=%h, required 0 0 0004", sb_q.size(), instr_valid, pc_reg);
    end
    for (int c = 0; c < 10; c++) begin
      redirect    = (c == 4);
      redirect_pc = 16'h0055;
      #1;
      if (imem_rd !== 1'b0 || pc_store !== 1'b0 || halt !== 1'b1 || instr_valid !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    redirect = 1'b0;
    vectors++;
    if (bad != 0 || pc_reg !== 16'h0004) begin
      miscompares++;
      $display("FAIL halt_hold: got %0d bad cycles pc=%h, required 0 0004", bad, pc_reg);
    end
  endtask

  task automatic test_reset_mid_wait;
    reset_dut(16'h0000);
    vectors++;
    if (halt !== 1'b0) begin
      miscompares++;
      $display("FAIL rmw_halt_clear: got %b, required 0", halt);
    end
    instr_ready = 1'b1;
    sb_q.push_back('{instr: 16'h1000, pc: 16'h0000});
    repeat (5) @(posedge clk);
    #1;
    vectors++;
    if (pc_store !== 1'b1 || instr !== 16'h1000 || pc_reg !== 16'h0001) begin
      miscompares++;
      $display("FAIL rmw_in_wait: got store=%b instr=%h pc=%h, required 1 1000 0001", pc_store, instr, pc_reg);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if ({instr, instr_pc, instr_valid, halt, pc_store, imem_rd} !== 36'h0 || pc_next !== pc_reg) begin
      miscompares++;
      $display("FAIL rmw_async: got instr=%h pc=%h v=%b h=%b st=%b rd=%b next=%h, required zeros next=%h",
               instr, instr_pc, instr_valid, halt, pc_store, imem_rd, pc_next, pc_reg);
    end
    @(posedge clk); #1;
    vectors++;
    if (pc_reg !== 16'h0001) begin
      miscompares++;
      $display("FAIL rmw_no_pc_write: got %h, required 0001", pc_reg);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (imem_rd !== 1'b1 || imem_addr !== 16'h0001 || instr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rmw_restart: got rd=%b addr=%h v=%b, required 1 0001 0", imem_rd, imem_addr, instr_valid);
    end
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL rmw_drain: got %0d pending, required 0", sb_q.size());
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    preset_en   = 1'b0;
    preset_val  = 16'h0000;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    halt_en     = 1'b0;
    halt_addr   = 16'h0000;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_valid();
    test_wrap();
    test_halt();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
